// File: rtl/pulse_blinker_pkg.sv
// Shared definitions for the board I/O helpers: the LED pulse blinker and the button debouncer.
package pulse_blinker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } blink_state_e;

  localparam int CLK_HZ            = 100_000_000;
  localparam int BLINK_ON_DEFAULT  = CLK_HZ / 4;   // 250 ms
  localparam int BLINK_OFF_DEFAULT = CLK_HZ / 4;   // 250 ms
  localparam int TIMER_LIMIT       = CLK_HZ / 100; // debouncer settle window, 10 ms

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_blinker_if.sv
// Event-in / LED-out bundle between the event logic (master) and the blinker (slave).
interface pulse_blinker_if #(
  parameter int PEND_W = 4
) ();
  logic              pulse_in;
  logic              clear;
  logic              led_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (output pulse_in, clear, input led_out, busy, pending, overflow);
  modport slave  (input pulse_in, clear, output led_out, busy, pending, overflow);
endinterface

// File: rtl/pulse_blinker_blink_timer.sv
// Phase timer: up-counter with synchronous restart and a terminal-count flag at a
// caller-selected last value, so one counter serves both the ON and OFF phases.
module blink_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         tc
);
  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  assign tc = (count == last);
endmodule

// File: rtl/pulse_blinker.sv
// Turns single-cycle event strobes into visible LED blinks; events that arrive while a
// blink is running are counted and replayed, up to 2^PEND_W-1 of them.
module pulse_blinker
  import pulse_blinker_pkg::*;
#(
  parameter int ON_CYCLES  = BLINK_ON_DEFAULT,
  parameter int OFF_CYCLES = BLINK_OFF_DEFAULT,
  parameter int PEND_W     = 4
) (
  input logic           clk,
  input logic           rst_n,
  pulse_blinker_if.slave bus
);
  localparam int TW = $clog2(max2(ON_CYCLES, OFF_CYCLES) + 1);
  localparam logic [TW-1:0]     ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  blink_state_e      state;
  logic              led_q, busy_q, ovf_q;
  logic [PEND_W-1:0] pend_q;

  logic          t_clr, t_en, t_tc;
  logic [TW-1:0] t_last;
  logic          off_done, replay, inc, dec;

  // Timer sits at 0 while idle and restarts on every phase boundary.
  assign t_last = (state == ON) ? ON_LAST : OFF_LAST;
  assign t_clr  = bus.clear || (state == IDLE) || t_tc;
  assign t_en   = (state != IDLE);

  blink_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (t_clr),
    .en    (t_en),
    .last  (t_last),
    .tc    (t_tc)
  );

  assign off_done = (state == OFF) && t_tc;
  assign replay   = off_done && ((pend_q != '0) || bus.pulse_in);
  assign dec      = off_done && (pend_q != '0);
  // A pulse landing on the last OFF cycle with nothing queued starts the next blink directly.
  assign inc      = bus.pulse_in && (state != IDLE) && !(off_done && (pend_q == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      led_q  <= 1'b0;
      busy_q <= 1'b0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else if (bus.clear) begin
      state  <= IDLE;
      led_q  <= 1'b0;
      busy_q <= 1'b0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.pulse_in) begin
          state  <= ON;
          led_q  <= 1'b1;
          busy_q <= 1'b1;
        end
        ON: if (t_tc) begin
          state <= OFF;
          led_q <= 1'b0;
        end
        OFF: if (t_tc) begin
          if (replay) begin
            state <= ON;
            led_q <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          led_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase

      if (inc && !dec) begin
        if (pend_q == PEND_MAX) ovf_q  <= 1'b1;
        else                    pend_q <= pend_q + 1'b1;
      end else if (!inc && dec) begin
        pend_q <= pend_q - 1'b1;
      end
    end
  end

  assign bus.led_out  = led_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;
endmodule
